// File: rtl/pi_bus_master_if.sv
// Request/response handshake and pi_* bus signals between the host command path,
// pi_bus_master and the responding block.
interface pi_bus_master_if #(
    parameter int BLK_W  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [BLK_W-1:0]  req_blk;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [BLK_W-1:0]  pi_blk_sel;
    logic [ADDR_W-1:0] pi_addr;
    logic              pi_wr_en;
    logic              pi_rd_en;
    logic [DATA_W-1:0] pi_wr_data;
    logic [DATA_W-1:0] pi_rd_data;

    modport master (
        input  req_valid, req_wr, req_blk, req_addr, req_wdata, rsp_ready, pi_rd_data,
        output req_ready, rsp_valid, rsp_rdata, busy,
               pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data
    );

    modport slave (
        output req_valid, req_wr, req_blk, req_addr, req_wdata, rsp_ready, pi_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data
    );
endinterface

// File: rtl/pi_bus_master.sv
// Initiator for the pi_* processor bus: request stream in, one-cycle strobes out,
// fixed-latency read capture. Define PI_BUS_MASTER_STATS_EN to add transfer counters.
module pi_bus_master #(
    parameter int BLK_W  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pi_bus_master_if.master       bus
`ifdef PI_BUS_MASTER_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_wr_cnt,
    output logic [15:0]           stat_rd_cnt
`endif
);
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT, S_RSP} state_t;

    state_t            state_reg;
    logic [3:0]        lat_cnt_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              busy_reg;
    logic [BLK_W-1:0]  pi_blk_sel_reg;
    logic [ADDR_W-1:0] pi_addr_reg;
    logic              pi_wr_en_reg;
    logic              pi_rd_en_reg;
    logic [DATA_W-1:0] pi_wr_data_reg;
    logic              rd_sample;

    // The capture edge is RD_LAT edges after the one that raised pi_rd_en.
    always_comb begin
        rd_sample = ((state_reg == S_RD) && (LAT_INIT == 4'd0)) ||
                    ((state_reg == S_RD_WAIT) && (lat_cnt_reg == 4'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            lat_cnt_reg    <= 4'd0;
            req_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            busy_reg       <= 1'b0;
            pi_blk_sel_reg <= '0;
            pi_addr_reg    <= '0;
            pi_wr_en_reg   <= 1'b0;
            pi_rd_en_reg   <= 1'b0;
            pi_wr_data_reg <= '0;
        end else begin
            pi_wr_en_reg <= 1'b0;
            pi_rd_en_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        req_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        pi_blk_sel_reg <= bus.req_blk;
                        pi_addr_reg    <= bus.req_addr;
                        if (bus.req_wr) begin
                            state_reg      <= S_WR;
                            pi_wr_en_reg   <= 1'b1;
                            pi_wr_data_reg <= bus.req_wdata;
                        end else begin
                            state_reg      <= S_RD;
                            pi_rd_en_reg   <= 1'b1;
                            pi_wr_data_reg <= '0;
                            lat_cnt_reg    <= LAT_INIT;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                S_WR: begin
                    state_reg      <= S_IDLE;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    pi_blk_sel_reg <= '0;
                    pi_addr_reg    <= '0;
                    pi_wr_data_reg <= '0;
                end
                S_RD, S_RD_WAIT: begin
                    if (rd_sample) begin
                        state_reg      <= S_RSP;
                        rsp_valid_reg  <= 1'b1;
                        rsp_rdata_reg  <= bus.pi_rd_data;
                        pi_blk_sel_reg <= '0;
                        pi_addr_reg    <= '0;
                    end else begin
                        state_reg <= S_RD_WAIT;
                        if (state_reg == S_RD_WAIT) begin
                            lat_cnt_reg <= lat_cnt_reg - 4'd1;
                        end
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= S_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_rdata  = rsp_rdata_reg;
    assign bus.busy       = busy_reg;
    assign bus.pi_blk_sel = pi_blk_sel_reg;
    assign bus.pi_addr    = pi_addr_reg;
    assign bus.pi_wr_en   = pi_wr_en_reg;
    assign bus.pi_rd_en   = pi_rd_en_reg;
    assign bus.pi_wr_data = pi_wr_data_reg;

`ifdef PI_BUS_MASTER_STATS_EN
    // Index 0 counts write strobes, index 1 counts completed read responses.
    logic [1:0] stat_inc;
    assign stat_inc[0] = (state_reg == S_WR);
    assign stat_inc[1] = (state_reg == S_RSP) && bus.rsp_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || stat_clr) begin
                    cnt_reg <= 16'd0;
                end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_wr_cnt = g_stat[0].cnt_reg;
    assign stat_rd_cnt = g_stat[1].cnt_reg;
`endif
endmodule

// File: tb/tb_pi_bus_master.sv
// Scoreboard bench for pi_bus_master: expected bus strobes and read responses are
// queued when requests are accepted and popped by negedge monitors.
module tb_pi_bus_master;
    localparam int BLK_W  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    pi_bus_master_if #(.BLK_W(BLK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef PI_BUS_MASTER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
`endif

    pi_bus_master #(.BLK_W(BLK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PI_BUS_MASTER_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus-side responder: data appears only in the cycle before the capture edge.
    logic [31:0] mem    [4096];
    logic [31:0] shadow [4096];
    logic        rd_v = 1'b0;
    logic [31:0] rd_d = '0;

    always @(posedge clk) begin
        rd_v <= bus.pi_rd_en;
        rd_d <= mem[{bus.pi_blk_sel, bus.pi_addr}];
        if (bus.pi_wr_en) mem[{bus.pi_blk_sel, bus.pi_addr}] <= bus.pi_wr_data;
    end
    assign bus.pi_rd_data = rd_v ? rd_d : 32'hA5A5_A5A5;

    logic [44:0] bus_q [$];
    logic [31:0] rsp_q [$];
    bit          mon_en = 1'b0;
    bit          gap_chk = 1'b0;
    int          cyc = 0;
    int          last_wr_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (!gap_chk) last_wr_cyc = -1;
        if (mon_en) begin
            if (bus.pi_wr_en || bus.pi_rd_en) begin
                chk("strobe_excl", 64'(bus.pi_wr_en & bus.pi_rd_en), 64'd0);
                chk("bus_expected", 64'(bus_q.size() != 0), 64'd1);
                if (bus_q.size() != 0)
                    chk("bus_txn", 64'({bus.pi_wr_en, bus.pi_blk_sel, bus.pi_addr, bus.pi_wr_data}),
                        64'(bus_q.pop_front()));
                $display("bus %s blk=%h addr=%h wdata=%h", bus.pi_wr_en ? "wr" : "rd",
                         bus.pi_blk_sel, bus.pi_addr, bus.pi_wr_data);
                if (bus.pi_wr_en) begin
                    if (gap_chk && last_wr_cyc >= 0) chk("wr_gap", 64'(cyc - last_wr_cyc), 64'd2);
                    last_wr_cyc = cyc;
                end
            end else if (!bus.busy) begin
                chk("idle_bus", 64'({bus.pi_blk_sel, bus.pi_addr, bus.pi_wr_data}), 64'd0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) chk("rsp_data", 64'(bus.rsp_rdata), 64'(rsp_q.pop_front()));
                $display("rsp rdata=%h", bus.rsp_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called and returns at 1 time unit after a rising edge; returns in the cycle after accept.
    task automatic send(input bit wr, input logic [3:0] blk, input logic [7:0] addr,
                        input logic [31:0] wd, input bit exp_rsp, input bit hold);
        int n = 0;
        logic [11:0] idx;
        idx = {blk, addr};
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_blk   = blk;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(bus.req_ready), 64'd1);
        if (bus.req_ready) begin
            step();
            bus_q.push_back({wr, blk, addr, wr ? wd : 32'd0});
            if (wr) shadow[idx] = wd;
            else if (exp_rsp) rsp_q.push_back(shadow[idx]);
        end
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || bus.busy) && n < 100) begin
            step();
            n++;
        end
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 32'(i) * 32'h0101_0101 ^ 32'hC0DE_0000;
            shadow[i] = mem[i];
        end
        mem[12'h104]    = 32'h1234_5678;
        shadow[12'h104] = 32'h1234_5678;

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_blk   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) step();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'd0);
        chk("rst_pi", 64'({bus.pi_wr_en, bus.pi_rd_en, bus.pi_blk_sel, bus.pi_addr, bus.pi_wr_data}), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Single write
        send(1'b1, 4'h2, 8'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("wr_strobe", 64'({bus.pi_wr_en, bus.pi_rd_en, bus.busy, bus.rsp_valid}), 64'b1010);
        chk("wr_fields", 64'({bus.pi_blk_sel, bus.pi_addr, bus.pi_wr_data}), 64'({4'h2, 8'h10, 32'hDEAD_BEEF}));
        step();
        chk("wr_done", 64'({bus.pi_wr_en, bus.busy, bus.req_ready}), 64'b001);

        // Read with latency check and response back-pressure
        send(1'b0, 4'h1, 8'h04, 32'h0, 1'b1, 1'b0);
        chk("rd_strobe", 64'({bus.pi_rd_en, bus.pi_wr_en, bus.rsp_valid}), 64'b100);
        step();
        chk("rd_wait", 64'({bus.pi_rd_en, bus.rsp_valid, bus.busy, bus.pi_addr}), 64'({3'b001, 8'h04}));
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({1'b1, 32'h1234_5678}));
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            if (i < 4) step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("rsp_release", 64'({bus.rsp_valid, bus.req_ready, bus.busy}), 64'b010);

        // Back-to-back writes with req_valid held
        gap_chk = 1'b1;
        for (int i = 0; i < 4; i++)
            send(1'b1, 4'h5, 8'(i), 32'hA000_0000 + 32'(i), 1'b0, i < 3);
        drain();
        gap_chk = 1'b0;

        // Reset during RD_WAIT discards the read
        send(1'b0, 4'h3, 8'h20, 32'h0, 1'b0, 1'b0);
        step();
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_outs", 64'({bus.req_ready, bus.rsp_valid, bus.busy, bus.pi_wr_en, bus.pi_rd_en,
                                 bus.pi_blk_sel, bus.pi_addr}), 64'd0);
        chk("mid_rst_data", 64'({bus.rsp_rdata, bus.pi_wr_data}), 64'd0);
        rst = 1'b0;
        repeat (6) step();
        send(1'b0, 4'h2, 8'h33, 32'h0, 1'b1, 1'b0);
        drain();

        // Mixed random traffic over a small address window
        for (int i = 0; i < 20; i++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            send(wr, 4'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom, 1'b1,
                 1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        drain();

`ifdef PI_BUS_MASTER_STATS_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 4'h7, 8'(i), 32'h5000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) send(1'b0, 4'h7, 8'(i), 32'h0, 1'b1, 1'b0);
        drain();
        chk("stat_wr", 64'(stat_wr_cnt), 64'd3);
        chk("stat_rd", 64'(stat_rd_cnt), 64'd2);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr", 64'({stat_wr_cnt, stat_rd_cnt}), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
